fan_off_timer: RTL and testbench

//   Fan auto-off countdown timer, MM:SS in BCD. Downstream consumer of the 1 s tick chain.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_borrow_digit.sv | 38 +++
 rtl/fan_off_timer.sv | 187 ++++++++++++++++++
 tb/tb_fan_off_timer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the fan auto-off timer: state encodings, preset count
// and the minutes-to-BCD helper used when the presets are elaborated.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int NUM_PRESETS = 4;

    // Returns {tens, units}; callers keep minutes within 0..99.
    function automatic logic [7:0] min_to_bcd(input logic [6:0] minutes);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(minutes / 7'd10);
        units = 4'(minutes % 7'd10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_borrow_digit.sv
// One loadable BCD down-counting digit. Load wins over decrement; a decrement
// at zero wraps to MAX and raises borrow_out for the next-higher digit.
module bcd_borrow_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       dec_en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/fan_off_timer.sv
// Fan auto-off countdown timer (MM:SS, BCD) driven by the 1 s tick. Buttons pick
// a preset and start/pause/cancel; a one-cycle timeout pulse marks 00:00.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | preset selection; digits show the selected preset
// ST_RUN   | counting down on clk_sec, fan enabled
// ST_PAUSE | countdown frozen, digits held
// ST_DONE  | reached 00:00; any button returns to IDLE
module fan_off_timer
    import timer_pkg::*;
#(
    parameter int P1_MIN = 1,
    parameter int P2_MIN = 3,
    parameter int P3_MIN = 5
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clk_sec,
    input  logic       btn_set,
    input  logic       btn_start,
    input  logic       btn_cancel,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [3:0] sec_10,
    output logic [3:0] sec_1,
    output logic [1:0] state,
    output logic       running,
    output logic       timeout
);

    localparam logic [7:0] P1_BCD = min_to_bcd(7'(P1_MIN));
    localparam logic [7:0] P2_BCD = min_to_bcd(7'(P2_MIN));
    localparam logic [7:0] P3_BCD = min_to_bcd(7'(P3_MIN));

    function automatic logic [15:0] preset_digits(input logic [1:0] idx);
        logic [15:0] val;
        case (idx)
            2'd1:    val = {P1_BCD, 8'h00};
            2'd2:    val = {P2_BCD, 8'h00};
            2'd3:    val = {P3_BCD, 8'h00};
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        running_q, running_d;
    logic        timeout_q, timeout_d;

    logic        load;
    logic [15:0] load_val;
    logic        tick_dec;
    logic        b_s1, b_s10, b_m1, b_m10;
    logic [15:0] digits;
    logic        digits_zero;
    logic        digits_one;

    assign digits      = {min_10, min_1, sec_10, sec_1};
    assign digits_zero = (digits == 16'h0000);
    assign digits_one  = (digits == 16'h0001);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load      = 1'b0;
        load_val  = 16'h0000;
        tick_dec  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_cancel) begin
                    idx_d = 2'd0;
                    load  = 1'b1;
                end else if (btn_start) begin
                    if (!digits_zero) state_d = ST_RUN;
                end else if (btn_set) begin
                    idx_d    = idx_q + 2'd1;
                    load     = 1'b1;
                    load_val = preset_digits(idx_d);
                end
            end
            ST_RUN: begin
                if (btn_cancel) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    load    = 1'b1;
                end else if (btn_start) begin
                    state_d = ST_PAUSE;
                end else if (clk_sec && !digits_zero) begin
                    tick_dec = 1'b1;
                    if (digits_one) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (btn_cancel) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    load    = 1'b1;
                end else if (btn_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (btn_cancel || btn_start || btn_set) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                load    = 1'b1;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
        end
    end

    // Borrow ripples from seconds units up to minutes tens within one cycle.
    bcd_borrow_digit #(.MAX(4'd9)) u_sec_1 (
        .clk        (clk),
        .reset_p    (reset_p),
        .dec_en     (tick_dec),
        .load       (load),
        .load_val   (load_val[3:0]),
        .digit      (sec_1),
        .borrow_out (b_s1)
    );

    bcd_borrow_digit #(.MAX(4'd5)) u_sec_10 (
        .clk        (clk),
        .reset_p    (reset_p),
        .dec_en     (b_s1),
        .load       (load),
        .load_val   (load_val[7:4]),
        .digit      (sec_10),
        .borrow_out (b_s10)
    );

    bcd_borrow_digit #(.MAX(4'd9)) u_min_1 (
        .clk        (clk),
        .reset_p    (reset_p),
        .dec_en     (b_s10),
        .load       (load),
        .load_val   (load_val[11:8]),
        .digit      (min_1),
        .borrow_out (b_m1)
    );

    bcd_borrow_digit #(.MAX(4'd9)) u_min_10 (
        .clk        (clk),
        .reset_p    (reset_p),
        .dec_en     (b_m1),
        .load       (load),
        .load_val   (load_val[15:12]),
        .digit      (min_10),
        .borrow_out (b_m10)
    );

    // Decrement is gated off at 00:00, so the top digit can never borrow.
    always_comb begin
        if (!reset_p) assert (!b_m10);
    end

    assign state   = state_q;
    assign running = running_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_fan_off_timer.sv
// Directed bench for fan_off_timer: presets, full countdown, pause, cancel
// races and asynchronous reset, with hand-computed expected values.
module tb_fan_off_timer;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       clk_sec = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_cancel = 1'b0;
    logic [3:0] min_10, min_1, sec_10, sec_1;
    logic [1:0] state;
    logic       running;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    fan_off_timer #(.P1_MIN(1), .P2_MIN(3), .P3_MIN(10)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .clk_sec    (clk_sec),
        .btn_set    (btn_set),
        .btn_start  (btn_start),
        .btn_cancel (btn_cancel),
        .min_10     (min_10),
        .min_1      (min_1),
        .sec_10     (sec_10),
        .sec_1      (sec_1),
        .state      (state),
        .running    (running),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    wire [15:0] digits = {min_10, min_1, sec_10, sec_1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs from a falling edge; returns on the next falling edge.
    task automatic step(input logic s, input logic st, input logic c, input logic sec);
        @(negedge clk);
        btn_set    = s;
        btn_start  = st;
        btn_cancel = c;
        clk_sec    = sec;
        @(negedge clk);
        btn_set    = 1'b0;
        btn_start  = 1'b0;
        btn_cancel = 1'b0;
        clk_sec    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #23;
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_digits", 32'(digits), 32'h0000);
        chk("reset_running", 32'(running), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        reset_p = 1'b0;

        // Preset 2, full 3-minute countdown; tick alongside start is dropped.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("preset1", 32'(digits), 32'h0100);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("preset2", 32'(digits), 32'h0300);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("start_state", 32'(state), 32'h1);
        chk("start_running", 32'(running), 32'h1);
        chk("start_tick_ignored", 32'(digits), 32'h0300);
        ticks(1);
        chk("first_tick", 32'(digits), 32'h0259);
        ticks(59);
        chk("tick60", 32'(digits), 32'h0200);
        ticks(119);
        chk("tick179", 32'(digits), 32'h0001);
        chk("tick179_timeout", 32'(timeout), 32'h0);
        ticks(1);
        chk("tick180_digits", 32'(digits), 32'h0000);
        chk("tick180_state", 32'(state), 32'h3);
        chk("tick180_timeout", 32'(timeout), 32'h1);
        chk("tick180_running", 32'(running), 32'h0);
        ticks(1);
        chk("timeout_one_cycle", 32'(timeout), 32'h0);
        chk("done_holds", 32'(digits), 32'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("done_set_to_idle", 32'(state), 32'h0);
        chk("done_set_consumed", 32'(digits), 32'h0000);

        // Preset 1, pause and resume.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("p1_after_done", 32'(digits), 32'h0100);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        chk("run5", 32'(digits), 32'h0055);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_state", 32'(state), 32'h2);
        chk("pause_running", 32'(running), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_set_ignored", 32'(digits), 32'h0055);
        ticks(10);
        chk("pause_hold", 32'(digits), 32'h0055);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_state", 32'(state), 32'h1);
        ticks(1);
        chk("resume_tick", 32'(digits), 32'h0054);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("cancel_run_state", 32'(state), 32'h0);
        chk("cancel_run_digits", 32'(digits), 32'h0000);

        // Start at 00:00 is a no-op.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_zero_state", 32'(state), 32'h0);
        chk("start_zero_running", 32'(running), 32'h0);

        // Preset 3 (10 min) exercises the minutes-tens borrow; then wrap to preset 0.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("preset3", 32'(digits), 32'h1000);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("borrow_1000", 32'(digits), 32'h0959);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("preset_wrap", 32'(digits), 32'h0000);

        // Cancel racing the final tick: no timeout.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(59);
        chk("race_at_one", 32'(digits), 32'h0001);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("race_state", 32'(state), 32'h0);
        chk("race_digits", 32'(digits), 32'h0000);
        chk("race_timeout", 32'(timeout), 32'h0);
        ticks(1);
        chk("race_timeout_after", 32'(timeout), 32'h0);

        // Asynchronous reset mid-run at 02:17.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(43);
        chk("pre_reset", 32'(digits), 32'h0217);
        #2 reset_p = 1'b1;
        #1;
        chk("async_rst_digits", 32'(digits), 32'h0000);
        chk("async_rst_state", 32'(state), 32'h0);
        chk("async_rst_running", 32'(running), 32'h0);
        @(negedge clk);
        reset_p = 1'b0;
        ticks(5);
        chk("post_rst_ticks", 32'(digits), 32'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_start", 32'(state), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("post_rst_idx0", 32'(digits), 32'h0059);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
